fetch_byte_queue: RTL and testbench

Two-line instruction byte queue that sits directly upstream of the 16-byte left rotator in the fetch/align path. It accepts aligned 16-byte fetch lines and tracks a byte read offset. Each cycle it presents the rotator with a merged line and a rotate amount, so the rotator output starts at the oldest unconsumed byte. Decode reports how many bytes it consumed, and the queue advances, retiring a line whenever the offset crosses a line boundary.

---
 rtl/fetch_byte_queue_if.sv | 27 ++
 rtl/fetch_byte_queue.sv | 72 +++++++
 tb/tb_fetch_byte_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_byte_queue_if.sv
// Fill / flush / consume handshake and rotator-facing outputs of the fetch byte queue.
// The queue binds to the slave modport; the fetch/decode side binds to the master modport.
interface fetch_byte_queue_if #(
  parameter int NUM_BYTES = 16,
  parameter int AMT_W     = $clog2(NUM_BYTES)
);
  logic                   fill_valid;
  logic [NUM_BYTES*8-1:0] fill_data;
  logic                   fill_ready;
  logic                   flush;
  logic [AMT_W-1:0]       flush_offset;
  logic                   consume_valid;
  logic [AMT_W:0]         consume_len;
  logic                   win_valid;
  logic [AMT_W+1:0]       avail_bytes;
  logic [NUM_BYTES*8-1:0] rot_data;
  logic [AMT_W-1:0]       rot_amt;

  modport master (
    output fill_valid, fill_data, flush, flush_offset, consume_valid, consume_len,
    input  fill_ready, win_valid, avail_bytes, rot_data, rot_amt
  );
  modport slave (
    input  fill_valid, fill_data, flush, flush_offset, consume_valid, consume_len,
    output fill_ready, win_valid, avail_bytes, rot_data, rot_amt
  );
endinterface

// File: rtl/fetch_byte_queue.sv
// Two-line instruction byte queue feeding the 16-byte left rotator in the fetch/align path.
// Holds a head line, a next line and a byte offset into the head line.
module fetch_byte_queue #(
  parameter int NUM_BYTES = 16,
  parameter int AMT_W     = $clog2(NUM_BYTES)
) (
  input  logic                clk,
  input  logic                rst,
  fetch_byte_queue_if.slave   bus
);
  localparam int LW = NUM_BYTES * 8;

  logic [1:0][LW-1:0] line;
  logic [1:0]         v;
  logic               hd;
  logic [AMT_W-1:0]   off;

  logic               tl;
  logic               fill_fire;
  logic               cons_fire;
  logic [AMT_W:0]     sum;

  // Tail slot: the head when the queue is empty, otherwise the other slot.
  assign tl        = v[hd] ? ~hd : hd;
  assign bus.fill_ready = ~(v[0] & v[1]) & ~bus.flush;
  assign fill_fire = bus.fill_valid & bus.fill_ready;
  assign bus.win_valid  = v[hd] & ((off == '0) | v[~hd]);
  assign cons_fire = bus.consume_valid & bus.win_valid & ~bus.flush;
  assign sum       = {1'b0, off} + bus.consume_len;

  assign bus.avail_bytes = (v[hd]  ? ((AMT_W+2)'(NUM_BYTES) - (AMT_W+2)'(off)) : '0)
                         + (v[~hd] ? (AMT_W+2)'(NUM_BYTES) : '0);
  assign bus.rot_amt     = AMT_W'(NUM_BYTES) - off;

  // Bytes below the offset are already consumed in the head line, so they are
  // backfilled from the next line; rotating by -off then yields a contiguous window.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_merge
    assign bus.rot_data[8*i +: 8] = (AMT_W'(i) >= off) ? line[hd][8*i +: 8]
                                                       : line[~hd][8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
      v    <= '0;
      hd   <= 1'b0;
      off  <= '0;
    end else if (bus.flush) begin
      v    <= '0;
      hd   <= 1'b0;
      off  <= bus.flush_offset;
    end else begin
      if (fill_fire) begin
        line[tl] <= bus.fill_data;
        v[tl]    <= 1'b1;
      end
      // A consume needs v[hd]=1, so tl differs from hd and the two updates never collide.
      if (cons_fire) begin
        off <= sum[AMT_W-1:0];
        if (sum[AMT_W]) begin
          v[hd] <= 1'b0;
          hd    <= ~hd;
        end
      end
    end
  end

  a_consume_len : assert property (@(posedge clk) disable iff (rst)
    bus.consume_valid |-> (bus.consume_len <= (AMT_W+1)'(NUM_BYTES)))
    else $error("consume_len %0d exceeds line width", bus.consume_len);

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed, table-driven bench for fetch_byte_queue: each row is one cycle of
// inputs plus the state expected after that edge, followed by a mid-operation reset.
module tb_fetch_byte_queue;
  localparam int N = 16;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_byte_queue_if #(.NUM_BYTES(N), .AMT_W(A)) bus ();
  fetch_byte_queue #(.NUM_BYTES(N), .AMT_W(A)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit         fv;
    logic [7:0] fb;
    bit         fl;
    logic [3:0] fo;
    bit         cv;
    logic [4:0] cl;
    bit         e_fr;
    bit         e_wv;
    logic [5:0] e_av;
    logic [3:0] e_amt;
    bit         chk;
    logic [7:0] e_base;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];
  int checks = 0;
  int errors = 0;

  function automatic logic [N*8-1:0] mkline(input logic [7:0] base);
    logic [N*8-1:0] d;
    for (int i = 0; i < N; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  // Reference left rotator: output byte j is input byte (j - amt) mod N.
  function automatic logic [N*8-1:0] rotl(input logic [N*8-1:0] d, input logic [3:0] amt);
    logic [N*8-1:0] o;
    for (int j = 0; j < N; j++) o[8*j +: 8] = d[8*((j + N - int'(amt)) % N) +: 8];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.fill_valid    = 1'b0;
    bus.fill_data     = '0;
    bus.flush         = 1'b0;
    bus.flush_offset  = '0;
    bus.consume_valid = 1'b0;
    bus.consume_len   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    //        fv  fb     fl fo  cv cl  fr wv av  amt chk base
    tv[0]  = '{1, 8'h00, 0, 0,  0, 0,  1, 1, 16, 0,  1, 8'h00}; // fill A
    tv[1]  = '{1, 8'h10, 0, 0,  0, 0,  0, 1, 32, 0,  1, 8'h00}; // fill B
    tv[2]  = '{1, 8'h70, 0, 0,  0, 0,  0, 1, 32, 0,  1, 8'h00}; // third fill held
    tv[3]  = '{0, 8'h00, 0, 0,  1, 5,  0, 1, 27, 11, 1, 8'h05}; // consume 5
    tv[4]  = '{0, 8'h00, 0, 0,  1, 12, 1, 0, 15, 15, 0, 8'h00}; // consume 12, crosses
    tv[5]  = '{1, 8'h20, 0, 0,  0, 0,  0, 1, 31, 15, 1, 8'h11}; // fill C
    tv[6]  = '{1, 8'h50, 1, 13, 0, 0,  1, 0, 0,  3,  0, 8'h00}; // flush, fill dropped
    tv[7]  = '{1, 8'h30, 0, 0,  0, 0,  1, 0, 3,  3,  0, 8'h00}; // fill D
    tv[8]  = '{1, 8'h40, 0, 0,  0, 0,  0, 1, 19, 3,  1, 8'h3D}; // fill E
    tv[9]  = '{0, 8'h00, 1, 0,  0, 0,  1, 0, 0,  0,  0, 8'h00}; // flush to 0
    tv[10] = '{1, 8'h60, 0, 0,  0, 0,  1, 1, 16, 0,  1, 8'h60}; // fill F
    tv[11] = '{0, 8'h00, 0, 0,  1, 16, 1, 0, 0,  0,  0, 8'h00}; // consume 16, single line
    tv[12] = '{1, 8'h80, 0, 0,  0, 0,  1, 1, 16, 0,  1, 8'h80}; // fill G into slot 1
    tv[13] = '{0, 8'h00, 0, 0,  1, 0,  1, 1, 16, 0,  1, 8'h80}; // consume 0 no-op
    tv[14] = '{0, 8'h00, 0, 0,  1, 3,  1, 0, 13, 13, 0, 8'h00}; // consume 3
    tv[15] = '{0, 8'h00, 0, 0,  1, 4,  1, 0, 13, 13, 0, 8'h00}; // ignored, no window
    tv[16] = '{1, 8'h90, 0, 0,  0, 0,  0, 1, 29, 13, 1, 8'h83}; // fill H
    tv[17] = '{0, 8'h00, 0, 0,  1, 13, 1, 1, 16, 0,  1, 8'h90}; // consume 13, retire G
    tv[18] = '{1, 8'hA0, 0, 0,  1, 16, 1, 1, 16, 0,  1, 8'hA0}; // fill I + retire H
    tv[19] = '{1, 8'hB0, 0, 0,  0, 0,  0, 1, 32, 0,  1, 8'hA0}; // fill J

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset fill_ready",  128'(bus.fill_ready),  128'(1));
    chk("reset win_valid",   128'(bus.win_valid),   128'(0));
    chk("reset avail_bytes", 128'(bus.avail_bytes), 128'(0));
    chk("reset rot_amt",     128'(bus.rot_amt),     128'(0));
    chk("reset rot_data",    128'(bus.rot_data),    128'(0));
    tick();
    chk("idle win_valid",    128'(bus.win_valid),   128'(0));
    chk("idle avail_bytes",  128'(bus.avail_bytes), 128'(0));

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      bus.fill_valid    = tv[k].fv;
      bus.fill_data     = mkline(tv[k].fb);
      bus.flush         = tv[k].fl;
      bus.flush_offset  = tv[k].fo;
      bus.consume_valid = tv[k].cv;
      bus.consume_len   = tv[k].cl;
      tick();
      chk($sformatf("v%0d fill_ready", k),  128'(bus.fill_ready),  128'(tv[k].e_fr));
      chk($sformatf("v%0d win_valid", k),   128'(bus.win_valid),   128'(tv[k].e_wv));
      chk($sformatf("v%0d avail_bytes", k), 128'(bus.avail_bytes), 128'(tv[k].e_av));
      chk($sformatf("v%0d rot_amt", k),     128'(bus.rot_amt),     128'(tv[k].e_amt));
      if (tv[k].chk)
        chk($sformatf("v%0d window", k), rotl(bus.rot_data, bus.rot_amt), mkline(tv[k].e_base));
    end

    // Flush asserted in a cycle must pull fill_ready low combinationally.
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush fill_ready", 128'(bus.fill_ready), 128'(0));
    bus.flush = 1'b0;

    // Reset with both lines valid, a consume and a fill all active.
    @(negedge clk);
    rst               = 1'b1;
    bus.consume_valid = 1'b1;
    bus.consume_len   = 5'd5;
    bus.fill_valid    = 1'b1;
    bus.fill_data     = mkline(8'hC0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    #1;
    chk("midrst fill_ready",  128'(bus.fill_ready),  128'(1));
    chk("midrst win_valid",   128'(bus.win_valid),   128'(0));
    chk("midrst avail_bytes", 128'(bus.avail_bytes), 128'(0));
    chk("midrst rot_amt",     128'(bus.rot_amt),     128'(0));
    chk("midrst rot_data",    128'(bus.rot_data),    128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
